pc_sequencer: RTL

Multi-cycle fetch/execute controller that owns the CPU program counter and sequences it through instruction memory. It replaces the free-running counter with a PC register that advances only on instruction completion. It loads branch targets from the datapath and supports halt and resume. It sits between the instruction memory port and the execute datapath.

---
 rtl/pc_sequencer.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/pc_sequencer.sv
// Fetch/decode/execute sequencer that owns the program counter and drives the instruction-memory port.
// Optional build macro PC_WRAP_TRAP_EN: a sequential PC wrap traps into HALT and sets a sticky wrap_err.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | after reset, waiting for start (or halt_req) to begin
// S_FETCH  | imem_req held with imem_addr=pc until imem_ack
// S_DECODE | instr_valid pulse, instr holds the fetched word
// S_EXEC   | waiting for exec_done, then pc advances or branches
// S_HALT   | stopped at an instruction boundary, waiting for start
module pc_sequencer #(
  parameter int ADDR_W    = 6,
  parameter int INSTR_W   = 32,
  parameter int RESET_VEC = 0
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_start,
  output logic               o_imem_req,
  output logic [ADDR_W-1:0]  o_imem_addr,
  input  logic               i_imem_ack,
  input  logic [INSTR_W-1:0] i_imem_rdata,
  output logic [INSTR_W-1:0] o_instr,
  output logic               o_instr_valid,
  input  logic               i_exec_done,
  input  logic               i_branch_taken,
  input  logic [ADDR_W-1:0]  i_branch_target,
  input  logic               i_halt_req,
  output logic [ADDR_W-1:0]  o_pc,
  output logic [2:0]         o_state,
  output logic               o_halted,
  output logic               o_wrap_err
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  localparam logic [ADDR_W-1:0] C_RESET_PC = ADDR_W'(RESET_VEC);

  state_t               r_state;
  logic [ADDR_W-1:0]    r_pc;
  logic [INSTR_W-1:0]   r_instr;
  logic                 r_imem_req;
  logic                 r_instr_valid;
  logic                 r_halted;
  logic                 r_halt_pending;
  logic [ADDR_W-1:0]    w_pc_next;
  logic                 w_trap;

  assign w_pc_next = i_branch_taken ? i_branch_target : r_pc + ADDR_W'(1);

`ifdef PC_WRAP_TRAP_EN
  localparam logic [ADDR_W-1:0] C_PC_MAX = '1;
  logic w_wrap;
  logic r_wrap_err;

  // Only a sequential increment out of the top address counts; a branch to 0 does not.
  assign w_wrap = (r_state == S_EXEC) && i_exec_done && !i_branch_taken && (r_pc == C_PC_MAX);
  assign w_trap = w_wrap;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wrap_err <= 1'b0;
    end else if (w_wrap) begin
      r_wrap_err <= 1'b1;
    end
  end

  assign o_wrap_err = r_wrap_err;
`else
  assign w_trap     = 1'b0;
  assign o_wrap_err = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state        <= S_IDLE;
      r_pc           <= C_RESET_PC;
      r_instr        <= '0;
      r_imem_req     <= 1'b0;
      r_instr_valid  <= 1'b0;
      r_halted       <= 1'b0;
      r_halt_pending <= 1'b0;
    end else begin
      r_instr_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_state    <= S_FETCH;
            r_imem_req <= 1'b1;
          end else if (i_halt_req) begin
            r_state  <= S_HALT;
            r_halted <= 1'b1;
          end
        end
        S_FETCH: begin
          if (i_halt_req) r_halt_pending <= 1'b1;
          if (i_imem_ack) begin
            r_instr       <= i_imem_rdata;
            r_imem_req    <= 1'b0;
            r_instr_valid <= 1'b1;
            r_state       <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (i_halt_req) r_halt_pending <= 1'b1;
          r_state <= S_EXEC;
        end
        S_EXEC: begin
          if (i_exec_done) begin
            r_pc <= w_pc_next;
            // Halt is taken only here, so an instruction is never cut short.
            if (r_halt_pending || i_halt_req || w_trap) begin
              r_state        <= S_HALT;
              r_halted       <= 1'b1;
              r_halt_pending <= 1'b0;
            end else begin
              r_state    <= S_FETCH;
              r_imem_req <= 1'b1;
            end
          end else if (i_halt_req) begin
            r_halt_pending <= 1'b1;
          end
        end
        S_HALT: begin
          if (i_start && !i_halt_req) begin
            r_state    <= S_FETCH;
            r_imem_req <= 1'b1;
            r_halted   <= 1'b0;
          end
        end
        default: begin
          r_state        <= S_IDLE;
          r_imem_req     <= 1'b0;
          r_halted       <= 1'b0;
          r_halt_pending <= 1'b0;
        end
      endcase
    end
  end

  assign o_imem_req    = r_imem_req;
  assign o_imem_addr   = r_pc;
  assign o_pc          = r_pc;
  assign o_instr       = r_instr;
  assign o_instr_valid = r_instr_valid;
  assign o_state       = r_state;
  assign o_halted      = r_halted;

endmodule
